// File: rtl/input_conditioner_n_pkg.sv
// input_conditioner_n_pkg: repeat-state encoding and sizing helpers
// shared by the button conditioner and its per-channel chain.
package input_conditioner_n_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   function automatic int db_cycles(input int clk_hz, input int debounce_us);
      int c;
      c = clk_hz / 1000000 * debounce_us;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_n_channel.sv
// input_conditioner_n_channel: one button's polarity fix, sync, debounce,
// press detect, auto-repeat and frame-aligned one-shot.
module input_conditioner_n_channel
   import input_conditioner_n_pkg::*;
#(
   parameter int DB_CYCLES          = 1,
   parameter int REPEAT_DELAY_TICKS = 20,
   parameter int REPEAT_RATE_TICKS  = 5,
   parameter int ACTIVE_LOW         = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic tick_input,
   input  logic repeat_en,
   output logic btn_level,
   output logic btn_final
);

   localparam int DB   = (DB_CYCLES < 1) ? 1 : DB_CYCLES;
   localparam int DLY  = (REPEAT_DELAY_TICKS < 1) ? 1 : REPEAT_DELAY_TICKS;
   localparam int RATE = (REPEAT_RATE_TICKS < 1) ? 1 : REPEAT_RATE_TICKS;
   localparam int CW   = cnt_width(DB);
   localparam int RW   = cnt_width((DLY > RATE) ? DLY : RATE);
   localparam logic [CW-1:0] DB_LAST   = CW'(DB - 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(DLY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(RATE - 1);

   logic          in_bit, sync1_q, sync2_q;
   logic          level_q, level_d, level_dly_q;
   logic          pend_q, pend_d, final_q, final_d;
   logic          press, rep, evt;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   rpt_state_e    state_q, state_d;

   always_comb begin
      in_bit   = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
      press    = level_q & ~level_dly_q;
      level_d  = level_q;
      db_cnt_d = '0;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) level_d = ~level_q;
         else db_cnt_d = db_cnt_q + CW'(1);
      end
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rep     = 1'b0;
      // Release or disable aborts repeating and wins over a same-cycle repeat.
      if (!level_q || !repeat_en) begin
         state_d = RPT_IDLE;
         rcnt_d  = '0;
      end else if (state_q == RPT_IDLE) begin
         if (press) begin
            state_d = RPT_DELAY;
            rcnt_d  = '0;
         end
      end else if (tick_input) begin
         if (rcnt_q == ((state_q == RPT_DELAY) ? DLY_LAST : RATE_LAST)) begin
            rep     = 1'b1;
            rcnt_d  = '0;
            state_d = RPT_REPEAT;
         end else begin
            rcnt_d = rcnt_q + RW'(1);
         end
      end
      evt     = press | rep;
      final_d = tick_input & pend_q;
      pend_d  = tick_input ? evt : (pend_q | evt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         db_cnt_q    <= '0;
         rcnt_q      <= '0;
         state_q     <= RPT_IDLE;
         pend_q      <= 1'b0;
         final_q     <= 1'b0;
      end else begin
         sync1_q     <= in_bit;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         db_cnt_q    <= db_cnt_d;
         rcnt_q      <= rcnt_d;
         state_q     <= state_d;
         pend_q      <= pend_d;
         final_q     <= final_d;
      end
   end

   assign btn_level = level_q;
   assign btn_final = final_q;

endmodule

// File: rtl/input_conditioner_n.sv
// input_conditioner_n: N independent button channels producing debounced
// levels and at most one frame-aligned action pulse per frame each.
module input_conditioner_n
   import input_conditioner_n_pkg::*;
#(
   parameter int N_CH               = 4,
   parameter int CLK_HZ             = 50000000,
   parameter int DEBOUNCE_US        = 5000,
   parameter int REPEAT_DELAY_TICKS = 20,
   parameter int REPEAT_RATE_TICKS  = 5,
   parameter int ACTIVE_LOW         = 1
) (
   input  logic            CLOCK_50,
   input  logic            resetn,
   input  logic [N_CH-1:0] btn_raw,
   input  logic            tick_input,
   input  logic [N_CH-1:0] repeat_en,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_final
);

   localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_US);

   genvar i;
   generate
      for (i = 0; i < N_CH; i++) begin : g_ch
         input_conditioner_n_channel #(
            .DB_CYCLES         (DB_CYCLES),
            .REPEAT_DELAY_TICKS(REPEAT_DELAY_TICKS),
            .REPEAT_RATE_TICKS (REPEAT_RATE_TICKS),
            .ACTIVE_LOW        (ACTIVE_LOW)
         ) u_ch (
            .clk       (CLOCK_50),
            .rst_n     (resetn),
            .btn_raw   (btn_raw[i]),
            .tick_input(tick_input),
            .repeat_en (repeat_en[i]),
            .btn_level (btn_level[i]),
            .btn_final (btn_final[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_input_conditioner_n.sv
// tb_input_conditioner_n: directed scenarios plus random button activity,
// checked every cycle against a timing-rule model of the conditioner.
module tb_input_conditioner_n;

   localparam int N = 4, DB = 4, DLY = 3, RATE = 2, FRAME = 20;

   logic         CLOCK_50 = 1'b0, resetn = 1'b0, tick_input = 1'b0;
   logic [N-1:0] btn_raw = '1, repeat_en = '0, btn_level, btn_final;
   int           total = 0, bad = 0, cyc_n = 0, edge_n = 0, tick_mode = 0;

   // Model: levels flip after DB straight disagreeing samples (by edge time),
   // repeats fire on the tick counts DLY, DLY+RATE, DLY+2*RATE, ...
   logic [N-1:0] m_level, m_final, m_pend, m_rose, p1, p2;
   bit           trk[N];
   int           ticks[N], last_agree[N];

   input_conditioner_n #(
      .N_CH(N), .CLK_HZ(1000000), .DEBOUNCE_US(4),
      .REPEAT_DELAY_TICKS(DLY), .REPEAT_RATE_TICKS(RATE), .ACTIVE_LOW(1)
   ) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .btn_raw(btn_raw),
      .tick_input(tick_input), .repeat_en(repeat_en),
      .btn_level(btn_level), .btn_final(btn_final)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      m_level = '0; m_final = '0; m_pend = '0; m_rose = '0; p1 = '0; p2 = '0;
      for (int c = 0; c < N; c++) begin
         trk[c] = 0; ticks[c] = 0; last_agree[c] = edge_n;
      end
   endtask

   task automatic model_step();
      logic [N-1:0] p, nl;
      logic         press, rep, ev;
      edge_n++;
      p  = ~btn_raw;
      nl = m_level;
      for (int c = 0; c < N; c++) begin
         press = m_rose[c];
         rep   = 1'b0;
         if (!m_level[c] || !repeat_en[c]) trk[c] = 0;
         else if (press) begin trk[c] = 1; ticks[c] = 0; end
         else if (trk[c] && tick_input) begin
            ticks[c]++;
            rep = (ticks[c] == DLY) || (ticks[c] > DLY && (ticks[c] - DLY) % RATE == 0);
         end
         ev         = press | rep;
         m_final[c] = tick_input & m_pend[c];
         m_pend[c]  = tick_input ? ev : (m_pend[c] | ev);
         if (p2[c] == m_level[c]) last_agree[c] = edge_n;
         else if (edge_n - last_agree[c] == DB) begin
            nl[c] = ~m_level[c];
            last_agree[c] = edge_n;
         end
      end
      m_rose  = nl & ~m_level;
      m_level = nl;
      p2 = p1;
      p1 = p;
   endtask

   task automatic cyc();
      cyc_n++;
      tick_input = (tick_mode == 0) ? (cyc_n % FRAME == 0) :
                   (tick_mode == 1) ? ($urandom_range(0, 5) == 0) : 1'b0;
      @(posedge CLOCK_50);
      if (!resetn) begin edge_n++; model_reset(); end
      else model_step();
      #1;
      chk("level", btn_level, m_level);
      chk("final", btn_final, m_final);
   endtask

   task automatic align();
      while (cyc_n % FRAME != 0) cyc();
   endtask

   initial begin
      int n, k, frm, first, idx;
      logic seen;
      logic [15:0] got;
      model_reset();
      repeat (3) cyc();
      chk("reset_level", btn_level, 0);
      chk("reset_final", btn_final, 0);
      resetn = 1'b1;
      // clean press on channel 0
      align();
      k = cyc_n;
      btn_raw[0] = 1'b0;
      repeat (5) cyc();
      chk("clean_pre", btn_level[0], 0);
      cyc();
      chk("clean_rise", btn_level[0], 1);
      n = 0; first = 0;
      repeat (94) begin
         cyc();
         if (btn_final[0]) begin n++; if (first == 0) first = cyc_n; end
      end
      chk("clean_count", n, 1);
      chk("clean_when", first, k + FRAME);
      btn_raw[0] = 1'b1;
      repeat (40) cyc();
      // glitch on channel 1
      btn_raw[1] = 1'b0;
      repeat (3) cyc();
      btn_raw[1] = 1'b1;
      seen = 1'b0;
      repeat (40) begin cyc(); seen |= btn_level[1] | btn_final[1]; end
      chk("glitch", seen, 0);
      // two qualified presses inside one frame merge
      align();
      btn_raw[1] = 1'b0; repeat (6) cyc();
      btn_raw[1] = 1'b1; repeat (6) cyc();
      btn_raw[1] = 1'b0;
      n = 0;
      repeat (50) begin cyc(); n += int'(btn_final[1]); end
      chk("merge_count", n, 1);
      btn_raw[1] = 1'b1;
      repeat (30) cyc();
      // press landing on the tick cycle fires one frame later
      align();
      repeat (13) cyc();
      btn_raw[0] = 1'b0;
      repeat (7) cyc();
      chk("coin_tick", btn_final[0], 0);
      repeat (FRAME) cyc();
      chk("coin_next", btn_final[0], 1);
      btn_raw[0] = 1'b1;
      repeat (40) cyc();
      // auto-repeat on channel 2
      repeat_en[2] = 1'b1;
      align();
      btn_raw[2] = 1'b0;
      repeat (6) cyc();
      chk("rpt_rise", btn_level[2], 1);
      frm = 0; got = '0;
      repeat (12 * FRAME - 6 + 5) begin
         cyc();
         if (tick_input) frm++;
         if (btn_final[2] && frm < 16) got[frm] = 1'b1;
      end
      chk("rpt_frames", got, 16'h1552);
      btn_raw[2] = 1'b1;
      repeat (30) cyc();
      n = 0;
      repeat (60) begin cyc(); n += int'(btn_final[2]); end
      chk("rpt_stop", n, 0);
      // reset while repeating with an event pending
      btn_raw[2] = 1'b0;
      k = 0;
      while (!(m_pend[2] && ticks[2] >= DLY) && k < 300) begin cyc(); k++; end
      chk("rst_reach", k < 300, 1);
      resetn = 1'b0;
      #1;
      chk("rst_async_level", btn_level, 0);
      chk("rst_async_final", btn_final, 0);
      model_reset();
      cyc(); cyc();
      resetn = 1'b1;
      repeat (5) cyc();
      chk("rst_pre", btn_level[2], 0);
      cyc();
      chk("rst_rise", btn_level[2], 1);
      repeat (30) cyc();
      // simultaneous presses on channels 0 and 3
      btn_raw = '1; repeat_en = '0;
      repeat (60) cyc();
      btn_raw[0] = 1'b0; btn_raw[3] = 1'b0;
      k = 0;
      while (btn_final == '0 && k < 60) begin cyc(); k++; end
      chk("multi", btn_final, 4'b1001);
      btn_raw = '1;
      repeat (40) cyc();
      // random activity, including random and absent ticks
      for (int i = 0; i < 2400; i++) begin
         tick_mode = (i < 1400) ? 0 : (i < 2000) ? 1 : (i < 2200) ? 2 : 0;
         if ($urandom_range(0, 11) == 0) begin
            idx = $urandom_range(0, N - 1);
            btn_raw[idx] = ~btn_raw[idx];
         end
         if ($urandom_range(0, 149) == 0) repeat_en = N'($urandom);
         cyc();
      end
      btn_raw = '1;
      repeat (50) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
